// File: rtl/deskew_pkg.sv
// Shared types and defaults for the deskew shear engine.
//   state_t   : engine FSM states
//   IMG_W_DEF : default frame width in pixels
//   IMG_H_DEF : default frame height in pixels
//   ALPHA_ONE : alpha value representing 1.0 (Q4.12)
package deskew_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    PIX,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned IMG_W_DEF = 28;
  localparam int unsigned IMG_H_DEF = 28;
  localparam int unsigned ALPHA_ONE = 4096;

endpackage

// File: rtl/deskew_shear_if.sv
// Command/status and BRAM signal bundle for deskew_shear.
//   start/ready/alpha_i          : command register handshake and shear coefficient
//   in_addr_o/in_en_o/in_data_i  : input BRAM read port (data valid one cycle after enable)
//   out_addr_o/out_we_o/out_data_o : output BRAM write port
// slave  : the deskew engine side
// master : the command register / memory side
interface deskew_shear_if #(
  parameter int unsigned PIX_W   = 16,
  parameter int unsigned ALPHA_W = 16,
  parameter int unsigned ADDR_W  = 10
);

  logic               start;
  logic               ready;
  logic [ALPHA_W-1:0] alpha_i;
  logic [ADDR_W-1:0]  in_addr_o;
  logic               in_en_o;
  logic [PIX_W-1:0]   in_data_i;
  logic [ADDR_W-1:0]  out_addr_o;
  logic               out_we_o;
  logic [PIX_W-1:0]   out_data_o;

  modport slave (
    input  start, alpha_i, in_data_i,
    output ready, in_addr_o, in_en_o, out_addr_o, out_we_o, out_data_o
  );

  modport master (
    output start, alpha_i, in_data_i,
    input  ready, in_addr_o, in_en_o, out_addr_o, out_we_o, out_data_o
  );

endinterface

// File: rtl/deskew_offset_calc.sv
// Per-row horizontal shift for the shear.
//   y     : row index
//   alpha : signed shear coefficient, ALPHA_FRAC fractional bits
//   off   : round(alpha * (y - (IMG_H-1)/2)), rounded half up
// Computed as (alpha*(2y-(IMG_H-1)) + 2^ALPHA_FRAC) >>> (ALPHA_FRAC+1) so the
// half-row centre stays integer and no precision is lost before rounding.
module deskew_offset_calc
  import deskew_pkg::*;
#(
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned ALPHA_W    = 16,
  parameter int unsigned ALPHA_FRAC = 12,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned Y_W        = 5
) (
  input  logic        [Y_W-1:0]          y,
  input  logic signed [ALPHA_W-1:0]      alpha,
  output logic signed [ALPHA_W+ADDR_W:0] off
);

  localparam int unsigned PW = ALPHA_W + ADDR_W + 1;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** ALPHA_FRAC);
  localparam logic signed [PW-1:0] SPAN = PW'(IMG_H - 1);

  logic signed [PW-1:0] dy;
  logic signed [PW-1:0] alpha_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;

  assign dy      = $signed({{(PW-Y_W-1){1'b0}}, y, 1'b0}) - SPAN;
  assign alpha_x = {{(PW-ALPHA_W){alpha[ALPHA_W-1]}}, alpha};
  assign prod    = alpha_x * dy;
  assign sum     = prod + HALF;
  assign off     = sum >>> (ALPHA_FRAC + 1);

endmodule

// File: rtl/deskew_shear.sv
// Deskew engine: applies out(y,x) = in(y, x + off(y)) over one IMG_H x IMG_W
// frame, nearest neighbour, zero fill for out-of-range sources. One pixel per
// clock; reads the input BRAM and writes the output BRAM one cycle later.
//   clk   : clock, all logic on posedge
//   reset : asynchronous, active-high; returns engine to IDLE
//   bus   : start/ready/alpha and both BRAM ports (slave modport)
module deskew_shear
  import deskew_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned ALPHA_W    = 16,
  parameter int unsigned ALPHA_FRAC = 12,
  parameter int unsigned ADDR_W     = 10
) (
  input logic           clk,
  input logic           reset,
  deskew_shear_if.slave bus
);

  localparam int unsigned X_W = $clog2(IMG_W + 1);
  localparam int unsigned Y_W = $clog2(IMG_H + 1);
  localparam int unsigned PW  = ALPHA_W + ADDR_W + 1;
  localparam logic signed [PW-1:0] W_S = PW'(IMG_W);

  state_t state, state_nx;

  logic signed [ALPHA_W-1:0] alpha_r;
  logic        [X_W-1:0]     x;
  logic        [Y_W-1:0]     y;
  logic        [ADDR_W-1:0]  row_base;
  logic signed [PW-1:0]      off_calc;
  logic signed [PW-1:0]      off_r;
  logic signed [PW-1:0]      src;
  logic                      in_range;
  logic                      last_col;
  logic                      last_row;

  // read -> write pipeline stage
  logic              wr_valid;
  logic              wr_zero;
  logic [ADDR_W-1:0] wr_addr;

  deskew_offset_calc #(
    .IMG_H      (IMG_H),
    .ALPHA_W    (ALPHA_W),
    .ALPHA_FRAC (ALPHA_FRAC),
    .ADDR_W     (ADDR_W),
    .Y_W        (Y_W)
  ) u_offset (
    .y     (y),
    .alpha (alpha_r),
    .off   (off_calc)
  );

  assign src      = $signed({{(PW-X_W){1'b0}}, x}) + off_r;
  assign in_range = !src[PW-1] && (src < W_S);
  assign last_col = (x == X_W'(IMG_W - 1));
  assign last_row = (y == Y_W'(IMG_H - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ROW;
      ROW:     state_nx = PIX;
      PIX:     if (last_col) state_nx = last_row ? DRAIN : ROW;
      DRAIN:   state_nx = DONE;
      DONE:    if (!bus.start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alpha_r  <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      off_r    <= '0;
      wr_valid <= 1'b0;
      wr_zero  <= 1'b0;
      wr_addr  <= '0;
    end else begin
      wr_valid <= (state == PIX);
      wr_zero  <= !in_range;
      wr_addr  <= row_base + ADDR_W'(x);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            alpha_r  <= $signed(bus.alpha_i);
            y        <= '0;
            row_base <= '0;
          end
        end
        ROW: begin
          off_r <= off_calc;
          x     <= '0;
        end
        PIX: begin
          x <= x + 1'b1;
          if (last_col && !last_row) begin
            y        <= y + 1'b1;
            row_base <= row_base + ADDR_W'(IMG_W);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = (state == IDLE) || (state == DONE);
  assign bus.in_en_o    = (state == PIX) && in_range;
  assign bus.in_addr_o  = bus.in_en_o ? row_base + ADDR_W'(src) : '0;
  assign bus.out_we_o   = wr_valid;
  assign bus.out_addr_o = wr_addr;
  assign bus.out_data_o = (wr_valid && !wr_zero) ? bus.in_data_i : '0;

endmodule
